// File: rtl/register_file_32x32_pkg.sv
// Shared constants and helpers for the 32x32 register file.
// Word select and write decode live here so every port uses one definition.
package register_file_32x32_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int REG_COUNT  = 32;

  localparam logic [DATA_WIDTH-1:0] ZERO_WORD = '0;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [REG_COUNT-1:0][DATA_WIDTH-1:0] bank_t;

  // One-hot decode of a register index; bit 0 is never
  // produced since register 0 has no storage.
  function automatic logic [REG_COUNT-1:1] dec_hi(
    input addr_t a
  );
    logic [REG_COUNT-1:1] r;
    r = '0;
    for (int i = 1; i < REG_COUNT; i++) begin
      r[i] = (a == addr_t'(i));
    end
    return r;
  endfunction

  // 32:1 word multiplexer used for each read port.
  function automatic word_t mux32(
    input bank_t w,
    input addr_t a
  );
    return w[a];
  endfunction

endpackage

// File: rtl/register_file_32x32_reg32_en.sv
// Single word register with load enable.
// Reset has priority over the enable and clears the word.
import register_file_32x32_pkg::*;

module reg32_en #(
  parameter int W = DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // Next value: load when enabled, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (en) begin
      data_d = d;
    end
  end

  // Word storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/register_file_32x32.sv
// 32-entry x 32-bit register file, two registered reads, one write.
// Register 0 has no storage and always reads as zero.
import register_file_32x32_pkg::*;

module register_file_32x32 (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] ADDR_W,
  input  logic [DATA_WIDTH-1:0] DATA_W,
  output logic [DATA_WIDTH-1:0] DATA_R1,
  output logic [DATA_WIDTH-1:0] DATA_R2
);

  bank_t                reg_words;
  logic [REG_COUNT-1:1] wr_en;
  word_t                rd1_word;
  word_t                rd2_word;

  assign reg_words[0] = ZERO_WORD;

  // Write enables: index decode gated by WRITE.
  always_comb begin
    wr_en = dec_hi(ADDR_W) & {(REG_COUNT-1){WRITE}};
  end

  for (genvar i = 1; i < REG_COUNT; i++) begin : g_reg
    reg32_en #(
      .W (DATA_WIDTH)
    ) u_reg (
      .clk (CLK),
      .rst (RST),
      .en  (wr_en[i]),
      .d   (DATA_W),
      .q   (reg_words[i])
    );
  end

  // Read operand select from pre-edge contents (no bypass).
  always_comb begin
    rd1_word = mux32(reg_words, ADDR_R1);
    rd2_word = mux32(reg_words, ADDR_R2);
  end

  reg32_en #(
    .W (DATA_WIDTH)
  ) u_rd1 (
    .clk (CLK),
    .rst (RST),
    .en  (READ),
    .d   (rd1_word),
    .q   (DATA_R1)
  );

  reg32_en #(
    .W (DATA_WIDTH)
  ) u_rd2 (
    .clk (CLK),
    .rst (RST),
    .en  (READ),
    .d   (rd2_word),
    .q   (DATA_R2)
  );

endmodule

// File: tb/tb_register_file_32x32.sv
// Directed bench for register_file_32x32.
// Inputs change on the falling edge; outputs sampled 1 after rising.
module tb_register_file_32x32;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        READ = 1'b0;
  logic        WRITE = 1'b0;
  logic [4:0]  ADDR_R1 = '0;
  logic [4:0]  ADDR_R2 = '0;
  logic [4:0]  ADDR_W = '0;
  logic [31:0] DATA_W = '0;
  logic [31:0] DATA_R1;
  logic [31:0] DATA_R2;

  int vecs = 0;
  int errs = 0;

  register_file_32x32 dut (
    .CLK     (CLK),
    .RST     (RST),
    .READ    (READ),
    .WRITE   (WRITE),
    .ADDR_R1 (ADDR_R1),
    .ADDR_R2 (ADDR_R2),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DATA_R1 (DATA_R1),
    .DATA_R2 (DATA_R2)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(
    input logic        rst,
    input logic        rd,
    input logic        wr,
    input logic [4:0]  a1,
    input logic [4:0]  a2,
    input logic [4:0]  aw,
    input logic [31:0] dw
  );
    @(negedge CLK);
    RST = rst;
    READ = rd;
    WRITE = wr;
    ADDR_R1 = a1;
    ADDR_R2 = a2;
    ADDR_W = aw;
    DATA_W = dw;
    @(posedge CLK);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, a, d);
  endtask

  task automatic rd_reg(input logic [4:0] a1, input logic [4:0] a2);
    cyc(1'b0, 1'b1, 1'b0, a1, a2, 5'd0, 32'h0);
  endtask

  task automatic test_reset;
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    vecs++;
    if (DATA_R1 !== 32'h0) begin
      errs++;
      $display("FAIL rst_r1 got %h exp %h", DATA_R1, 32'h0);
    end
    vecs++;
    if (DATA_R2 !== 32'h0) begin
      errs++;
      $display("FAIL rst_r2 got %h exp %h", DATA_R2, 32'h0);
    end
    wr_reg(5'd5, 32'hDEADBEEF);
    cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    rd_reg(5'd5, 5'd5);
    vecs++;
    if (DATA_R1 !== 32'h0) begin
      errs++;
      $display("FAIL rst_clr_r1 got %h exp %h", DATA_R1, 32'h0);
    end
    vecs++;
    if (DATA_R2 !== 32'h0) begin
      errs++;
      $display("FAIL rst_clr_r2 got %h exp %h", DATA_R2, 32'h0);
    end
  endtask

  task automatic test_sweep;
    logic [31:0] e1;
    logic [31:0] e2;
    for (int i = 1; i < 32; i++) begin
      wr_reg(5'(i), 32'h1000_0000 + 32'(i));
    end
    for (int i = 0; i < 32; i++) begin
      rd_reg(5'(i), 5'(31 - i));
      e1 = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
      e2 = (i == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - i);
      vecs++;
      if (DATA_R1 !== e1) begin
        errs++;
        $display("FAIL sweep_r1[%0d] got %h exp %h", i, DATA_R1, e1);
      end
      vecs++;
      if (DATA_R2 !== e2) begin
        errs++;
        $display("FAIL sweep_r2[%0d] got %h exp %h", 31 - i, DATA_R2, e2);
      end
    end
  endtask

  task automatic test_r0;
    wr_reg(5'd0, 32'hFFFFFFFF);
    rd_reg(5'd0, 5'd0);
    vecs++;
    if (DATA_R1 !== 32'h0) begin
      errs++;
      $display("FAIL r0_r1 got %h exp %h", DATA_R1, 32'h0);
    end
    vecs++;
    if (DATA_R2 !== 32'h0) begin
      errs++;
      $display("FAIL r0_r2 got %h exp %h", DATA_R2, 32'h0);
    end
  endtask

  task automatic test_same_cycle;
    wr_reg(5'd7, 32'h11111111);
    cyc(1'b0, 1'b1, 1'b1, 5'd7, 5'd6, 5'd7, 32'h22222222);
    vecs++;
    if (DATA_R1 !== 32'h11111111) begin
      errs++;
      $display("FAIL rw_old got %h exp %h", DATA_R1, 32'h11111111);
    end
    vecs++;
    if (DATA_R2 !== 32'h10000006) begin
      errs++;
      $display("FAIL rw_other got %h exp %h", DATA_R2, 32'h10000006);
    end
    rd_reg(5'd7, 5'd7);
    vecs++;
    if (DATA_R1 !== 32'h22222222) begin
      errs++;
      $display("FAIL rw_new got %h exp %h", DATA_R1, 32'h22222222);
    end
  endtask

  task automatic test_hold;
    wr_reg(5'd3, 32'hA5A5A5A5);
    rd_reg(5'd3, 5'd4);
    vecs++;
    if (DATA_R1 !== 32'hA5A5A5A5) begin
      errs++;
      $display("FAIL hold_rd got %h exp %h", DATA_R1, 32'hA5A5A5A5);
    end
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0, 1'b0, (c == 0), 5'(c * 3), 5'(c), 5'd3, 32'h0);
      vecs++;
      if (DATA_R1 !== 32'hA5A5A5A5) begin
        errs++;
        $display("FAIL hold_r1[%0d] got %h exp %h", c, DATA_R1, 32'hA5A5A5A5);
      end
    end
    rd_reg(5'd3, 5'd3);
    vecs++;
    if (DATA_R1 !== 32'h0) begin
      errs++;
      $display("FAIL hold_after got %h exp %h", DATA_R1, 32'h0);
    end
  endtask

  task automatic test_reset_mid_write;
    rd_reg(5'd9, 5'd8);
    vecs++;
    if (DATA_R1 !== 32'h10000009) begin
      errs++;
      $display("FAIL pre_rst got %h exp %h", DATA_R1, 32'h10000009);
    end
    cyc(1'b1, 1'b1, 1'b1, 5'd9, 5'd8, 5'd9, 32'h12345678);
    vecs++;
    if (DATA_R1 !== 32'h0) begin
      errs++;
      $display("FAIL rst_rd_ignored got %h exp %h", DATA_R1, 32'h0);
    end
    rd_reg(5'd9, 5'd8);
    vecs++;
    if (DATA_R1 !== 32'h0) begin
      errs++;
      $display("FAIL rst_mid_wr got %h exp %h", DATA_R1, 32'h0);
    end
    vecs++;
    if (DATA_R2 !== 32'h0) begin
      errs++;
      $display("FAIL rst_mid_r8 got %h exp %h", DATA_R2, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_r0();
    test_same_cycle();
    test_hold();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
